// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges a bypassing ALU result stream and a 2-deep buffered
// memory result stream onto one registered register-file write port.
module wb_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            reg_write,
    output logic [4:0]      write_register,
    output logic [XLEN-1:0] write_data
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]      r_q_rd   [2];
    logic [XLEN-1:0] r_q_data [2];
    logic            r_head;
    logic [1:0]      r_count;
    logic [SW-1:0]   r_starve;
    logic            r_reg_write;
    logic [4:0]      r_wr_rd;
    logic [XLEN-1:0] r_wr_data;

    logic            w_empty, w_force_mem, w_grant_mem, w_grant_alu, w_grant;
    logic            w_enq, w_tail;
    logic [4:0]      w_sel_rd;
    logic [XLEN-1:0] w_sel_data;

    assign w_empty     = (r_count == 2'd0);
    assign w_force_mem = (r_starve == SW'(STARVE_LIMIT)) && !w_empty;
    assign alu_ready   = !w_force_mem;
    assign mem_ready   = (r_count < 2'd2);

    assign w_grant_mem = !w_empty && (w_force_mem || !alu_valid);
    assign w_grant_alu = alu_valid && alu_ready;
    assign w_grant     = w_grant_mem || w_grant_alu;
    // Full blocks enqueue even when the head drains this same cycle.
    assign w_enq       = mem_valid && mem_ready;
    assign w_tail      = r_head ^ r_count[0];

    assign w_sel_rd    = w_grant_mem ? r_q_rd[r_head]   : alu_rd;
    assign w_sel_data  = w_grant_mem ? r_q_data[r_head] : alu_data;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_rd[w_tail]   <= mem_rd;
            r_q_data[w_tail] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head   <= 1'b0;
            r_count  <= 2'd0;
            r_starve <= '0;
        end else begin
            if (w_grant_mem)
                r_head <= ~r_head;
            case ({w_enq, w_grant_mem})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_empty || w_grant_mem)
                r_starve <= '0;
            else if (w_grant_alu && r_starve != SW'(STARVE_LIMIT))
                r_starve <= r_starve + SW'(1);
        end
    end

    // Writes to x0 are consumed but never raise the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write <= 1'b0;
            r_wr_rd     <= '0;
            r_wr_data   <= '0;
        end else begin
            r_reg_write <= w_grant && (w_sel_rd != 5'd0);
            if (w_grant) begin
                r_wr_rd   <= w_sel_rd;
                r_wr_data <= w_sel_data;
            end
        end
    end

    assign reg_write      = r_reg_write;
    assign write_register = r_wr_rd;
    assign write_data     = r_wr_data;
endmodule
